// File: rtl/branch_predictor.sv
// Dynamic branch predictor beside IF: direct-mapped BTB with a saturating
// direction counter per entry and a saturating mispredict counter.
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CNT_BITS = 2,
    parameter int MODE     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_uncond,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [15:0] mispredict_count
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam bit DYNAMIC  = (MODE == 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_ONE << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_ONE;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
    logic [15:0]         mc_q, mc_d;

    // Lookup: purely combinational, sees pre-update contents.
    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic                rd_hit;

    assign rd_idx      = pc_if[IDX_BITS+1:2];
    assign rd_tag      = pc_if[IDX_BITS+1+TAG_BITS:IDX_BITS+2];
    assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken  = DYNAMIC && rd_hit && cnt_q[rd_idx][CNT_BITS-1];
    assign pred_target = pred_taken ? target_q[rd_idx] : 32'h0;

    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;
    logic                wr_hit;
    logic                wr_en;
    logic [31:0]         target_d;
    logic [CNT_BITS-1:0] cnt_d;

    assign wr_idx = upd_pc[IDX_BITS+1:2];
    assign wr_tag = upd_pc[IDX_BITS+1+TAG_BITS:IDX_BITS+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        wr_en    = 1'b0;
        target_d = target_q[wr_idx];
        cnt_d    = cnt_q[wr_idx];
        if (DYNAMIC && upd_valid) begin
            if (wr_hit) begin
                wr_en = 1'b1;
                if (upd_uncond) begin
                    cnt_d    = CNT_MAX;
                    target_d = upd_target;
                end else if (upd_taken) begin
                    cnt_d    = (cnt_q[wr_idx] == CNT_MAX) ? CNT_MAX : cnt_q[wr_idx] + CNT_ONE;
                    target_d = upd_target;
                end else begin
                    cnt_d    = (cnt_q[wr_idx] == '0) ? '0 : cnt_q[wr_idx] - CNT_ONE;
                end
            end else if (upd_taken || upd_uncond) begin
                // Allocation silently evicts whatever aliased into this slot.
                wr_en    = 1'b1;
                target_d = upd_target;
                cnt_d    = upd_uncond ? CNT_MAX : CNT_WT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (wr_en) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= target_d;
            cnt_q[wr_idx]    <= cnt_d;
        end
    end

    // Counts in both modes so static builds can still be profiled.
    assign mc_d = (upd_valid && upd_mispredict && (mc_q != 16'hFFFF)) ? mc_q + 16'd1 : mc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mc_q <= 16'h0;
        else       mc_q <= mc_d;
    end

    assign mispredict_count = mc_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: dynamic and static predictors share stimulus; expected
// predictions come from a behavioural BTB model and are checked by a monitor.
module tb_branch_predictor;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_if = 32'h40;
    logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_uncond = 1'b0, upd_mispredict = 1'b0;
    logic [31:0] upd_pc = 32'h0, upd_target = 32'h0;
    logic        pt1, pt0;
    logic [31:0] ptg1, ptg0;
    logic [15:0] mc1, mc0;

    branch_predictor #(.ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(1)) dut (
        .clock(clock), .reset(reset), .pc_if(pc_if), .pred_taken(pt1), .pred_target(ptg1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_uncond(upd_uncond),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .mispredict_count(mc1));

    branch_predictor #(.ENTRIES(16), .TAG_BITS(8), .CNT_BITS(2), .MODE(0)) dut0 (
        .clock(clock), .reset(reset), .pc_if(pc_if), .pred_taken(pt0), .pred_target(ptg0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_uncond(upd_uncond),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .mispredict_count(mc0));

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [15:0] mc;
    } exp_t;
    exp_t sb[$];

    // Behavioural model: a 16-slot table keyed by (pc/4) mod 16, tagged by (pc/64) mod 256.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_cnt   [16];
    int unsigned m_mc;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
        m_mc = 0;
    endfunction

    function automatic exp_t model_predict(logic [31:0] pc);
        exp_t e;
        int unsigned idx = (pc / 4) % 16;
        int unsigned tg  = (pc / 64) % 256;
        e.pc     = pc;
        e.taken  = m_valid[idx] && (m_tag[idx] == tg) && (m_cnt[idx] >= 2);
        e.target = e.taken ? m_tgt[idx] : 32'h0;
        e.mc     = 16'(m_mc);
        return e;
    endfunction

    function automatic void model_update(logic v, logic [31:0] pc, logic tk, logic un,
                                         logic [31:0] tgt, logic mp);
        int unsigned idx = (pc / 4) % 16;
        int unsigned tg  = (pc / 64) % 256;
        if (!v) return;
        if (mp && m_mc < 65535) m_mc++;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            if (un)      begin m_cnt[idx] = 3; m_tgt[idx] = tgt; end
            else if (tk) begin m_cnt[idx] = (m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3; m_tgt[idx] = tgt; end
            else         m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
        end else if (tk || un) begin
            m_valid[idx] = 1; m_tag[idx] = tg; m_tgt[idx] = tgt; m_cnt[idx] = un ? 3 : 2;
        end
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: the expectation is the pre-update prediction.
    task automatic cycle(logic v, logic [31:0] upc, logic tk, logic un, logic [31:0] tgt,
                         logic mp, logic [31:0] fpc, bit check);
        @(posedge clock); #1;
        upd_valid = v; upd_pc = upc; upd_taken = tk; upd_uncond = un;
        upd_target = tgt; upd_mispredict = mp; pc_if = fpc;
        if (check) sb.push_back(model_predict(fpc));
        model_update(v, upc, tk, un, tgt, mp);
        $display("[TB] cyc v=%0b upc=%h tk=%0b un=%0b tgt=%h mp=%0b pc_if=%h", v, upc, tk, un, tgt, mp, fpc);
    endtask

    task automatic idle(logic [31:0] fpc);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, fpc, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("dyn_taken pc=%h", e.pc), 32'(pt1), 32'(e.taken));
                chk($sformatf("dyn_target pc=%h", e.pc), ptg1, e.target);
                chk("dyn_mcount", 32'(mc1), 32'(e.mc));
                chk($sformatf("static_taken pc=%h", e.pc), 32'(pt0), 32'h0);
                chk("static_target", ptg0, 32'h0);
                chk("static_mcount", 32'(mc0), 32'(e.mc));
            end
        end
    end

    initial begin : driver
        logic [31:0] rpc, fpc;
        model_reset();
        #12;
        chk("reset_taken", 32'(pt1), 32'h0);
        chk("reset_target", ptg1, 32'h0);
        chk("reset_mcount", 32'(mc1), 32'h0);
        @(negedge clock); reset = 1'b0;

        // Allocation, same-cycle lookup sees old contents
        cycle(1, 32'h100, 1, 0, 32'h80, 1, 32'h100, 1);
        idle(32'h100);
        @(negedge clock);
        chk("alloc_taken", 32'(pt1), 32'h1);
        chk("alloc_target", ptg1, 32'h80);
        chk("alloc_mcount", 32'(mc1), 32'h1);
        chk("static_no_train", 32'(pt0), 32'h0);

        // Hysteresis on the counter
        cycle(1, 32'h100, 0, 0, 32'h0, 1, 32'h100, 1);
        idle(32'h100);
        cycle(1, 32'h100, 0, 0, 32'h0, 0, 32'h100, 1);
        cycle(1, 32'h100, 1, 0, 32'h84, 0, 32'h100, 1);
        idle(32'h100);
        @(negedge clock);
        chk("weak_nt_after_taken", 32'(pt1), 32'h0);

        // Alias eviction
        idle(32'h140);
        cycle(1, 32'h140, 1, 0, 32'h200, 1, 32'h140, 1);
        idle(32'h140);
        @(negedge clock);
        chk("alias_target", ptg1, 32'h200);
        idle(32'h100);
        @(negedge clock);
        chk("alias_evicted", 32'(pt1), 32'h0);

        // Saturation and unconditional allocation
        repeat (4) cycle(1, 32'h24, 1, 0, 32'h300, 0, 32'h24, 1);
        cycle(1, 32'h24, 0, 0, 32'h0, 1, 32'h24, 1);
        idle(32'h24);
        @(negedge clock);
        chk("sat_still_taken", 32'(pt1), 32'h1);
        cycle(1, 32'h3C, 0, 1, 32'h400, 1, 32'h3C, 1);
        cycle(1, 32'h3C, 0, 0, 32'h0, 1, 32'h3C, 1);
        idle(32'h3C);
        @(negedge clock);
        chk("uncond_strong", ptg1, 32'h400);

        // Randomized traffic over a small PC window to provoke hits and aliases
        for (int i = 0; i < 1500; i++) begin
            rpc = 32'($urandom_range(0, 127)) << 2;
            fpc = 32'($urandom_range(0, 127)) << 2;
            cycle(1'($urandom_range(0, 3) != 0), rpc, 1'($urandom), 1'($urandom_range(0, 7) == 0),
                  32'($urandom) & 32'hFFFF_FFFC, 1'($urandom), fpc, 1);
        end

        // Mispredict counter saturation
        for (int i = 0; i < 70000; i++)
            cycle(1, 32'($urandom_range(0, 127)) << 2, 1'($urandom), 0,
                  32'($urandom) & 32'hFFFF_FFFC, 1, 32'($urandom_range(0, 127)) << 2, (i % 7000) == 0);
        idle(32'h24);
        @(negedge clock);
        chk("mcount_sat_dyn", 32'(mc1), 32'hFFFF);
        chk("mcount_sat_static", 32'(mc0), 32'hFFFF);

        // Async reset mid-training: outputs clear instantly, update discarded
        cycle(1, 32'h24, 1, 0, 32'h300, 0, 32'h24, 0);
        @(posedge clock); #1;
        upd_valid = 1; upd_pc = 32'h80; upd_taken = 1; upd_uncond = 1;
        upd_target = 32'h500; upd_mispredict = 1; pc_if = 32'h24;
        #2 reset = 1'b1;
        #1;
        chk("async_taken", 32'(pt1), 32'h0);
        chk("async_target", ptg1, 32'h0);
        chk("async_mcount", 32'(mc1), 32'h0);
        chk("async_mcount_static", 32'(mc0), 32'h0);
        @(posedge clock); #3;
        reset = 1'b0; upd_valid = 0;
        model_reset();
        idle(32'h24);
        idle(32'h80);
        @(negedge clock);
        chk("post_reset_empty", 32'(pt1), 32'h0);
        idle(32'h140);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clock);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline. Today branches resolve in MEM and always flush.
- Sits beside the IF stage. Combinationally predicts taken/target for the current fetch PC.
- Trained at posedge by the resolving stage (MEM), which reports outcome, target and mispredict.
- Direct-mapped BTB plus N-bit saturating counter per entry; also keeps a saturating mispredict counter.

Parameters:
- ENTRIES, 16: number of table entries; power of two, 2..256. IDX_BITS = log2(ENTRIES).
- TAG_BITS, 8: tag width taken from PC above the index bits. 1 <= TAG_BITS <= 30-IDX_BITS.
- CNT_BITS, 2: saturating counter width, 1..4.
- MODE, 1: 0 = static not-taken (table inert); 1 = dynamic.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- pc_if  in  32  fetch PC to predict
- pred_taken  out  1  predict taken for pc_if
- pred_target  out  32  predicted target for pc_if; 0 when pred_taken=0
- upd_valid  in  1  training strobe, one resolved control-flow instruction per cycle
- upd_pc  in  32  PC of resolved instruction
- upd_taken  in  1  actual direction
- upd_uncond  in  1  instruction is jal/jalr (always taken)
- upd_target  in  32  actual target address
- upd_mispredict  in  1  pipeline flushed for this instruction
- mispredict_count  out  16  saturating count of mispredicts

Behaviour:
- Index = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+1+TAG_BITS : IDX_BITS+2].
- Per entry: valid, tag, target[31:0], counter[CNT_BITS-1:0].
- Lookup is combinational, zero latency:
  - hit = valid[idx] & (tag match).
  - pred_taken = MODE==1 & hit & counter MSB.
  - pred_target = table target if pred_taken, else 0.
- Training happens at posedge when upd_valid=1 and MODE==1.
  - Hit, upd_uncond=1: counter := all-ones; target := upd_target.
  - Hit, taken: counter := min(counter+1, max); target := upd_target.
  - Hit, not taken: counter := max(counter-1, 0); target unchanged.
  - Miss, taken or uncond: allocate and overwrite any alias. valid:=1, tag, target; counter := 2^(CNT_BITS-1) (weakly taken), or all-ones if uncond.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update contents (no bypass). The new value is visible the next cycle.
- CNT_BITS=1: the counter is a last-outcome bit.
- MODE==0: tables never written; pred_taken=0, pred_target=0.
- mispredict_count increments at posedge when upd_valid & upd_mispredict, in both modes. Holds at 0xFFFF.
- Reset (async, at any time including mid-training):
  - all valid:=0; counters := 2^(CNT_BITS-1)-1 (weakly not-taken); targets and tags := 0.
  - mispredict_count := 0.
  - Outputs immediately pred_taken=0, pred_target=0, mispredict_count=0.
  - An update coincident with reset is discarded.
- The table is sequential storage only; no other pipeline state is kept inside.

Test Plan:
All scenarios use defaults ENTRIES=16, TAG_BITS=8, CNT_BITS=2, MODE=1 unless stated.
- Reset, pc_if=0x40 -> pred_taken=0, pred_target=0, mispredict_count=0.
- One update upd_pc=0x100, taken, target=0x80, mispredict=1; then pc_if=0x100 -> pred_taken=1, pred_target=0x80, mispredict_count=1. In the update cycle itself, pc_if=0x100 still gives pred_taken=0.
- Not-taken update at 0x100 -> counter 2→1, pred_taken=0. Second not-taken -> counter 0. One taken -> counter 1, still pred_taken=0.
- Alias: 0x100 allocated, pc_if=0x140 (same index 0, different tag) -> pred_taken=0. Taken update at 0x140, target 0x200 -> pc_if=0x140 predicts 0x200; pc_if=0x100 now misses.
- Saturation: four taken updates at 0x24 -> counter 3. One not-taken -> counter 2, still taken. upd_uncond on a new PC -> counter 3 immediately. 70000 mispredict strobes -> mispredict_count=0xFFFF.
- MODE=0 build: taken updates at 0x100 -> pred_taken stays 0, mispredict_count still counts. Async reset asserted mid-run with upd_valid=1 -> all outputs 0 instantly, table empty after release.
